// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- handshaked ALU with registered outputs and an optional
// iterative multiplier.
//
// Sits between decode/issue and writeback. Both sides use valid/ready.
// Single-cycle operations produce a result one cycle after acceptance.
// MUL/MULHU use a radix-2 shift-add over a 2*WIDTH product register
// (one bit per cycle, fixed WIDTH-cycle iteration).
//
// Build option:
//   ALU_SEQ_MUL_EN  defined   -> opcodes E (MUL) / F (MULHU) are executed.
//                   undefined -> no multiplier is built. E/F complete in one
//                                cycle with result=0, flag=0, illegal=1, and
//                                busy is tied low.
//
// Parameters:
//   WIDTH      datapath width (power of 2, >= 8)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   operation request
//   in_ready   block can accept a request this cycle
//   op         operation code
//                0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 SLL 6 SRL 7 SRA
//                8 EQ 9 NE A LT B GE C LTU D GEU E MUL F MULHU
//   a, b       operands (shift amount = b[SHW-1:0])
//   out_valid  result/flag/illegal are valid
//   out_ready  consumer takes the result this cycle
//   result     registered result (compares: {0..0, flag})
//   flag       compare outcome, 0 for non-compare ops
//   illegal    op not supported in this build
//   busy       multiplier iterating
// ---------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag,
  output logic             illegal,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_SLL   = 4'h5;
  localparam logic [3:0] OP_SRL   = 4'h6;
  localparam logic [3:0] OP_SRA   = 4'h7;
  localparam logic [3:0] OP_EQ    = 4'h8;
  localparam logic [3:0] OP_NE    = 4'h9;
  localparam logic [3:0] OP_LT    = 4'hA;
  localparam logic [3:0] OP_GE    = 4'hB;
  localparam logic [3:0] OP_LTU   = 4'hC;
  localparam logic [3:0] OP_GEU   = 4'hD;
  localparam logic [3:0] OP_MUL   = 4'hE;
  localparam logic [3:0] OP_MULHU = 4'hF;

  localparam logic [1:0] ST_IDLE = 2'd0;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [1:0] ST_MUL  = 2'd1;
`endif
  localparam logic [1:0] ST_DONE = 2'd2;

  // Compare outcome. Signed compares use true two's-complement ordering,
  // never the sign of a-b, so they stay correct when a-b overflows.
  function automatic logic cmp_flag(input logic [3:0]       f_op,
                                    input logic [WIDTH-1:0] x,
                                    input logic [WIDTH-1:0] y);
    logic signed [WIDTH-1:0] xs;
    logic signed [WIDTH-1:0] ys;
    xs = x;
    ys = y;
    case (f_op)
      OP_EQ:   cmp_flag = (x == y);
      OP_NE:   cmp_flag = (x != y);
      OP_LT:   cmp_flag = (xs < ys);
      OP_GE:   cmp_flag = (xs >= ys);
      OP_LTU:  cmp_flag = (x < y);
      OP_GEU:  cmp_flag = (x >= y);
      default: cmp_flag = 1'b0;
    endcase
  endfunction

  // Single-cycle result. Multiply opcodes return zero here; they are either
  // handled by the iterative unit or reported as illegal.
  function automatic logic [WIDTH-1:0] alu_calc(input logic [3:0]       f_op,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    logic signed [WIDTH-1:0] xs;
    logic [SHW-1:0]          sh;
    xs = x;
    sh = y[SHW-1:0];
    case (f_op)
      OP_ADD: alu_calc = x + y;
      OP_SUB: alu_calc = x - y;
      OP_AND: alu_calc = x & y;
      OP_OR:  alu_calc = x | y;
      OP_XOR: alu_calc = x ^ y;
      OP_SLL: alu_calc = x << sh;
      OP_SRL: alu_calc = x >> sh;
      OP_SRA: alu_calc = xs >>> sh;
      OP_EQ, OP_NE, OP_LT, OP_GE, OP_LTU, OP_GEU:
        alu_calc = {{(WIDTH-1){1'b0}}, cmp_flag(f_op, x, y)};
      default: alu_calc = '0;
    endcase
  endfunction

  logic [1:0]       state;
  logic             accept;

  logic [WIDTH-1:0] sc_res;
  logic             sc_flag;
  logic             sc_ill;

  logic             vld_p1;
  logic [WIDTH-1:0] res_p1;
  logic             flag_p1;
  logic             ill_p1;

`ifdef ALU_SEQ_MUL_EN
  logic               is_mul;
  logic [2*WIDTH-1:0] prod_p0;
  logic [WIDTH-1:0]   mcand_p0;
  logic [SHW-1:0]     cnt_p0;
  logic               hi_p0;
  logic [WIDTH:0]     psum;
  logic [2*WIDTH-1:0] prod_nxt;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
`endif

  assign in_ready = (state == ST_IDLE) | ((state == ST_DONE) & out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    sc_res  = alu_calc(op, a, b);
    sc_flag = cmp_flag(op, a, b);
`ifdef ALU_SEQ_MUL_EN
    sc_ill  = 1'b0;
`else
    sc_ill  = (op == OP_MUL) | (op == OP_MULHU);
`endif
  end

`ifdef ALU_SEQ_MUL_EN
  assign is_mul = (op == OP_MUL) | (op == OP_MULHU);

  // Shift-add step: the multiplier occupies the low half of the product
  // register and is consumed LSB first while the partial sum grows in the
  // high half. The carry out of the add re-enters as the new top bit.
  always_comb begin
    psum     = {1'b0, prod_p0[2*WIDTH-1:WIDTH]}
             + (prod_p0[0] ? {1'b0, mcand_p0} : {(WIDTH+1){1'b0}});
    prod_nxt = {psum, prod_p0[WIDTH-1:1]};
  end

  assign busy = (state == ST_MUL);
`else
  assign busy = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      vld_p1   <= 1'b0;
      res_p1   <= '0;
      flag_p1  <= 1'b0;
      ill_p1   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      prod_p0  <= '0;
      mcand_p0 <= '0;
      cnt_p0   <= '0;
      hi_p0    <= 1'b0;
`endif
    end else begin
      case (state)
`ifdef ALU_SEQ_MUL_EN
        // p0 -> p1: iterate the multiplier, publish on the last step
        ST_MUL: begin
          prod_p0 <= prod_nxt;
          cnt_p0  <= cnt_p0 + 1'b1;
          if (cnt_p0 == CNT_LAST) begin
            state   <= ST_DONE;
            vld_p1  <= 1'b1;
            res_p1  <= hi_p0 ? prod_nxt[2*WIDTH-1:WIDTH] : prod_nxt[WIDTH-1:0];
            flag_p1 <= 1'b0;
            ill_p1  <= 1'b0;
          end
        end
`endif
        default: begin
          if (accept) begin
`ifdef ALU_SEQ_MUL_EN
            if (is_mul) begin
              // input -> p0: load the multiply operands
              state    <= ST_MUL;
              vld_p1   <= 1'b0;
              prod_p0  <= {{WIDTH{1'b0}}, b};
              mcand_p0 <= a;
              cnt_p0   <= '0;
              hi_p0    <= op[0];
            end else begin
`endif
              // input -> p1: single-cycle result
              state   <= ST_DONE;
              vld_p1  <= 1'b1;
              res_p1  <= sc_res;
              flag_p1 <= sc_flag;
              ill_p1  <= sc_ill;
`ifdef ALU_SEQ_MUL_EN
            end
`endif
          end else if ((state == ST_DONE) && out_ready) begin
            state  <= ST_IDLE;
            vld_p1 <= 1'b0;
          end
        end
      endcase
    end
  end

  assign out_valid = vld_p1;
  assign result    = res_p1;
  assign flag      = flag_p1;
  assign illegal   = ill_p1;

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq -- directed self-checking bench for alu_seq (WIDTH = 32).
// Expected values are hand-computed constants. Multiply expectations follow
// the build option ALU_SEQ_MUL_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_seq;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_SLL   = 4'h5;
  localparam logic [3:0] OP_SRL   = 4'h6;
  localparam logic [3:0] OP_SRA   = 4'h7;
  localparam logic [3:0] OP_EQ    = 4'h8;
  localparam logic [3:0] OP_NE    = 4'h9;
  localparam logic [3:0] OP_LT    = 4'hA;
  localparam logic [3:0] OP_GE    = 4'hB;
  localparam logic [3:0] OP_LTU   = 4'hC;
  localparam logic [3:0] OP_GEU   = 4'hD;
  localparam logic [3:0] OP_MUL   = 4'hE;
  localparam logic [3:0] OP_MULHU = 4'hF;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        flag;
  logic        illegal;
  logic        busy;

  int checks;
  int failures;

  alu_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag      (flag),
    .illegal   (illegal),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present a request and hold it until accepted; returns #1 after the
  // accepting edge with in_valid dropped.
  task automatic send(input string tag, input logic [3:0] o,
                      input logic [31:0] x, input logic [31:0] y);
    int n;
    n = 0;
    op = o;
    a = x;
    b = y;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Latency counts edges from the accepting edge (1) to the edge that
  // raises out_valid; busy is sampled once per cycle in between.
  task automatic run_op(input string tag, input logic [3:0] o,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] e_res, input logic e_flag,
                        input logic e_ill, input int e_lat, input int e_busy);
    int lat;
    int bc;
    send(tag, o, x, y);
    lat = 1;
    bc = 0;
    while (!out_valid && lat < 100) begin
      if (busy) bc++;
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_res"},  result, e_res);
    chk({tag, "_flag"}, {31'd0, flag}, {31'd0, e_flag});
    chk({tag, "_ill"},  {31'd0, illegal}, {31'd0, e_ill});
    chk({tag, "_lat"},  32'(lat), 32'(e_lat));
    chk({tag, "_busy"}, 32'(bc), 32'(e_busy));
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    op        = 4'h0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ovld",  {31'd0, out_valid}, 32'd0);
    chk("rst_res",   result, 32'd0);
    chk("rst_flag",  {31'd0, flag}, 32'd0);
    chk("rst_ill",   {31'd0, illegal}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_irdy",  {31'd0, in_ready}, 32'd1);
    rst = 1'b0;

    // Arithmetic / logic
    run_op("sub55",  OP_SUB, 32'd5, 32'd5, 32'd0, 1'b0, 1'b0, 1, 0);
    run_op("eq55",   OP_EQ,  32'd5, 32'd5, 32'd1, 1'b1, 1'b0, 1, 0);
    run_op("addwrap", OP_ADD, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1, 0);
    run_op("and",    OP_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 1, 0);
    run_op("or",     OP_OR,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b0, 1, 0);
    run_op("xor",    OP_XOR, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0, 1'b0, 1, 0);

    // Compares, including cases where a-b overflows
    run_op("lt_min1",  OP_LT,  32'h80000000, 32'h00000001, 32'd1, 1'b1, 1'b0, 1, 0);
    run_op("ge_min1",  OP_GE,  32'h80000000, 32'h00000001, 32'd0, 1'b0, 1'b0, 1, 0);
    run_op("lt_1min",  OP_LT,  32'h00000001, 32'h80000000, 32'd0, 1'b0, 1'b0, 1, 0);
    run_op("lt_maxmin", OP_LT, 32'h7FFFFFFF, 32'h80000000, 32'd0, 1'b0, 1'b0, 1, 0);
    run_op("ge_maxmin", OP_GE, 32'h7FFFFFFF, 32'h80000000, 32'd1, 1'b1, 1'b0, 1, 0);
    run_op("ltu",      OP_LTU, 32'h00000001, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b0, 1, 0);
    run_op("geu",      OP_GEU, 32'h00000001, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 1, 0);
    run_op("ne56",     OP_NE,  32'd5, 32'd6, 32'd1, 1'b1, 1'b0, 1, 0);

    // Shifts
    run_op("sra31",  OP_SRA, 32'h80000000, 32'd31, 32'hFFFFFFFF, 1'b0, 1'b0, 1, 0);
    run_op("srl31",  OP_SRL, 32'h80000000, 32'd31, 32'h00000001, 1'b0, 1'b0, 1, 0);
    run_op("sll32",  OP_SLL, 32'h12345678, 32'h20, 32'h12345678, 1'b0, 1'b0, 1, 0);
    run_op("sll4",   OP_SLL, 32'h00000001, 32'd4, 32'h00000010, 1'b0, 1'b0, 1, 0);
    run_op("sra0",   OP_SRA, 32'h80000001, 32'd0, 32'h80000001, 1'b0, 1'b0, 1, 0);
    run_op("sra_pos", OP_SRA, 32'h7FFFFFFF, 32'd31, 32'h00000000, 1'b0, 1'b0, 1, 0);
    run_op("srl4",   OP_SRL, 32'hF0000000, 32'd4, 32'h0F000000, 1'b0, 1'b0, 1, 0);

    // Multiply
`ifdef ALU_SEQ_MUL_EN
    run_op("mul_ff",   OP_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 33, 32);
    run_op("mulhu_ff", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0, 33, 32);
    run_op("mul_zero", OP_MUL,   32'd0, 32'd5, 32'd0, 1'b0, 1'b0, 33, 32);
    run_op("mulhu_2p32", OP_MULHU, 32'h00010000, 32'h00010000, 32'd1, 1'b0, 1'b0, 33, 32);
    run_op("mul_small", OP_MUL,  32'd1234, 32'd5678, 32'd7006652, 1'b0, 1'b0, 33, 32);
`else
    run_op("mul_ill",   OP_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b1, 1, 0);
    run_op("mulhu_ill", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b1, 1, 0);
`endif
    run_op("ill_clr", OP_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1, 0);

    // Backpressure: hold an ADD result for 5 cycles while a new request waits
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send("hold", OP_ADD, 32'd7, 32'd8);
    chk("hold_v0", {31'd0, out_valid}, 32'd1);
    chk("hold_r0", result, 32'd15);
    op = OP_ADD;
    a = 32'd0;
    b = 32'd10;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold_v%0d", i + 1), {31'd0, out_valid}, 32'd1);
      chk($sformatf("hold_r%0d", i + 1), result, 32'd15);
      chk($sformatf("hold_irdy%0d", i + 1), {31'd0, in_ready}, 32'd0);
    end

    // Stream 8 ADDs back to back; the first is the request held above
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = 32'(i);
      @(posedge clk);
      #1;
      chk($sformatf("strm_v%0d", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("strm_r%0d", i), result, 32'(i + 10));
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("strm_end", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of a multiply
`ifdef ALU_SEQ_MUL_EN
    send("rstmul", OP_MUL, 32'hFFFFFFFF, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    chk("rstmul_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rstmul_ovld", {31'd0, out_valid}, 32'd0);
    chk("rstmul_irdy", {31'd0, in_ready}, 32'd1);
    chk("rstmul_bsy0", {31'd0, busy}, 32'd0);
    run_op("rstmul_add", OP_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1, 0);
`endif

    // Reset while a result is held in DONE
    out_ready = 1'b0;
    send("rstdone", OP_ADD, 32'd1, 32'd1);
    chk("rstdone_v", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rstdone_ovld", {31'd0, out_valid}, 32'd0);
    chk("rstdone_irdy", {31'd0, in_ready}, 32'd1);
    chk("rstdone_res",  result, 32'd0);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rstdone_idle", {31'd0, out_valid}, 32'd0);
    run_op("rst_add", OP_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
